// File: rtl/level_controller.sv
// Frogger level sequencer: lane configuration per row, plus the
// level / lives / score state machine driven by collisions and frog-home.
module level_controller #(
  parameter int NUM_ROWS     = 4,
  parameter int MAX_LEVEL    = 8,
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [NUM_ROWS-1:0]   Car_Collision,
  input  logic                  Frog_Home,
  output logic [NUM_ROWS*3-1:0] Number_Cars,
  output logic [NUM_ROWS*8-1:0] Gap_Size,
  output logic [NUM_ROWS*5-1:0] Speed,
  output logic [NUM_ROWS-1:0]   Direction,
  output logic                  Row_Reset,
  output logic                  Frog_Reset,
  output logic [3:0]            Level,
  output logic [1:0]            Lives,
  output logic [7:0]            Score,
  output logic [2:0]            Game_State
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [3:0] MAX_LVL  = 4'(MAX_LEVEL);
  localparam logic [1:0] LIVES0   = 2'(START_LIVES);
  localparam logic [7:0] DIE_LAST = 8'(DEATH_FRAMES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] level_d;
  logic [1:0] lives_d;
  logic [7:0] score_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       row_d;
  logic       frog_d;
  logic [8:0] score_sum;

  assign score_sum  = {1'b0, Score} + {5'd0, Level};
  assign Game_State = state_q;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      Level      <= 4'd1;
      Lives      <= LIVES0;
      Score      <= 8'd0;
      cnt_q      <= 8'd0;
      Row_Reset  <= 1'b1;
      Frog_Reset <= 1'b1;
    end else begin
      state_q    <= state_d;
      Level      <= level_d;
      Lives      <= lives_d;
      Score      <= score_d;
      cnt_q      <= cnt_d;
      Row_Reset  <= row_d;
      Frog_Reset <= frog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = Level;
    lives_d = Lives;
    score_d = Score;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = PLAY;
          level_d = 4'd1;
          lives_d = LIVES0;
          score_d = 8'd0;
        end
      end
      PLAY: begin
        // collision takes priority over reaching home
        if (|Car_Collision) begin
          state_d = DYING;
          lives_d = (Lives == 2'd0) ? 2'd0 : Lives - 2'd1;
          cnt_d   = 8'd0;
        end else if (Frog_Home) begin
          state_d = LEVEL_UP;
          score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
          level_d = (Level >= MAX_LVL) ? Level : Level + 4'd1;
        end
      end
      DYING: begin
        if (cnt_q == DIE_LAST) begin
          state_d = (Lives == 2'd0) ? GAME_OVER : PLAY;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LEVEL_UP: state_d = PLAY;
      GAME_OVER: begin
        if (Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // strobes are registered against the state being entered
  always_comb begin
    row_d  = 1'b0;
    frog_d = 1'b1;
    unique case (state_d)
      IDLE:     row_d = 1'b1;
      PLAY: begin
        frog_d = 1'b0;
        row_d  = (state_q != PLAY);
      end
      LEVEL_UP: row_d = 1'b1;
      default:  row_d = 1'b0;
    endcase
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
    localparam logic [8:0] R9 = 9'(r);
    logic [8:0] sum;
    logic [8:0] spd;
    logic [8:0] ofs;
    assign sum = {5'd0, Level} + R9;
    assign spd = R9 + {4'd0, Level, 1'b0};
    assign ofs = {1'b0, Level, 4'd0} + {R9[5:0], 3'd0};
    assign Number_Cars[r*3 +: 3] =
      (sum >= 9'd6) ? 3'd4 : 3'(9'd1 + (sum >> 1));
    assign Speed[r*5 +: 5] =
      (spd > 9'd31) ? 5'd31 : spd[4:0];
    assign Gap_Size[r*8 +: 8] =
      (ofs >= 9'd120) ? 8'd40 : 8'(9'd160 - ofs);
    assign Direction[r] = ~R9[0];
  end

endmodule
